// File: rtl/sync_filter.sv
// sync_filter: multi-bit level synchronizer with a per-bit debounce filter.
// Each bit passes through a SYNC_STAGES-deep flop chain. It then drives a
// mismatch counter, which lets dout follow only after L consecutive
// disagreeing samples.
// Optional feature macro: SYNC_FILTER_EDGE_EN builds the registered
// dout_rise/dout_fall/dout_chg pulses. Without it those outputs are tied to 0.
module sync_filter #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILT_CNT_W  = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  filt_en,
    input  logic [FILT_CNT_W-1:0] filt_len,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] dout_rise,
    output logic [DATA_WIDTH-1:0] dout_fall,
    output logic                  dout_chg
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_filter: SYNC_STAGES must be at least 2");
    end

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_s;
    logic [DATA_WIDTH-1:0] dout_vec;
    logic [FILT_CNT_W-1:0] eff_len;

    // Plain flop chain with no logic between stages, so metastability can settle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_VALUE;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign eff_len = (filt_en && (filt_len != '0)) ? filt_len : FILT_CNT_W'(1);

`ifdef SYNC_FILTER_EDGE_EN
    logic [DATA_WIDTH-1:0] dout_nxt_vec;
`endif

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        logic [FILT_CNT_W-1:0] cnt_q;
        logic [FILT_CNT_W-1:0] cnt_nxt;
        logic [FILT_CNT_W:0]   cnt_inc;
        logic                  dout_q;
        logic                  dout_nxt;

        assign cnt_inc = {1'b0, cnt_q} + {{FILT_CNT_W{1'b0}}, 1'b1};

        // Count consecutive mismatches; follow s once the run reaches the effective length
        always_comb begin
            cnt_nxt  = cnt_q;
            dout_nxt = dout_q;
            if (sync_s[i] == dout_q) begin
                cnt_nxt = '0;
            end else if (cnt_inc >= {1'b0, eff_len}) begin
                dout_nxt = sync_s[i];
                cnt_nxt  = '0;
            end else begin
                cnt_nxt = cnt_inc[FILT_CNT_W-1:0];
            end
        end

        // Per-bit filter state; reset discards any partial count
        always_ff @(posedge clk) begin
            if (!rstn) begin
                cnt_q  <= '0;
                dout_q <= INIT_VALUE[i];
            end else begin
                cnt_q  <= cnt_nxt;
                dout_q <= dout_nxt;
            end
        end

        assign dout_vec[i] = dout_q;
`ifdef SYNC_FILTER_EDGE_EN
        assign dout_nxt_vec[i] = dout_nxt;
`endif
    end

    assign dout = dout_vec;

`ifdef SYNC_FILTER_EDGE_EN
    logic [DATA_WIDTH-1:0] rise_q;
    logic [DATA_WIDTH-1:0] fall_q;
    logic                  chg_q;

    // Edge pulses register on the same edge dout changes; reset suppresses them
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            rise_q <= dout_nxt_vec & ~dout_vec;
            fall_q <= ~dout_nxt_vec & dout_vec;
            chg_q  <= |(dout_nxt_vec ^ dout_vec);
        end
    end

    assign dout_rise = rise_q;
    assign dout_fall = fall_q;
    assign dout_chg  = chg_q;
`else
    assign dout_rise = '0;
    assign dout_fall = '0;
    assign dout_chg  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed bench for sync_filter. It is configured with
// SYNC_STAGES=3 and INIT_VALUE=16'h00F0.
// Inputs change on the falling edge, and outputs are checked on the falling edge.
// When SYNC_FILTER_EDGE_EN is undefined, the edge outputs are expected to stay 0.
module tb_sync_filter;

    logic        clk;
    logic        rstn;
    logic [15:0] din;
    logic        filt_en;
    logic [3:0]  filt_len;
    logic [15:0] dout;
    logic [15:0] dout_rise;
    logic [15:0] dout_fall;
    logic        dout_chg;

    int vectors;
    int miscompares;

    sync_filter #(
        .DATA_WIDTH (16),
        .SYNC_STAGES(3),
        .FILT_CNT_W (4),
        .INIT_VALUE (16'h00F0)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .din      (din),
        .filt_en  (filt_en),
        .filt_len (filt_len),
        .dout     (dout),
        .dout_rise(dout_rise),
        .dout_fall(dout_fall),
        .dout_chg (dout_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] exp_dout,
                               input logic [15:0] exp_rise, input logic [15:0] exp_fall,
                               input logic exp_chg);
        logic [15:0] er;
        logic [15:0] ef;
        logic        ec;
`ifdef SYNC_FILTER_EDGE_EN
        er = exp_rise;
        ef = exp_fall;
        ec = exp_chg;
`else
        er = 16'h0000;
        ef = 16'h0000;
        ec = 1'b0;
        if (exp_chg) begin
            er = 16'h0000;
        end
`endif
        vectors++;
        assert (dout === exp_dout) else begin
            miscompares++;
            $error("[TB] FAIL %s dout: got %h expected %h", tag, dout, exp_dout);
        end
        vectors++;
        assert (dout_rise === er) else begin
            miscompares++;
            $error("[TB] FAIL %s dout_rise: got %h expected %h", tag, dout_rise, er);
        end
        vectors++;
        assert (dout_fall === ef) else begin
            miscompares++;
            $error("[TB] FAIL %s dout_fall: got %h expected %h", tag, dout_fall, ef);
        end
        vectors++;
        assert (dout_chg === ec) else begin
            miscompares++;
            $error("[TB] FAIL %s dout_chg: got %b expected %b", tag, dout_chg, ec);
        end
    endtask

    // Directed scenarios run back to back; expected values are hand-derived edge counts
    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        din         = 16'hFFFF;
        filt_en     = 1'b0;
        filt_len    = 4'd0;

        $display("[TB] reset check");
        for (int k = 0; k < 3; k++) begin
            step(1);
            checkOutput("reset_hold", 16'h00F0, 16'h0000, 16'h0000, 1'b0);
        end
        rstn = 1'b1;
        step(1);
        checkOutput("reset_release", 16'h00F0, 16'h0000, 16'h0000, 1'b0);
        step(2);
        checkOutput("bypass_all_e3", 16'h00F0, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("bypass_all_e4", 16'hFFFF, 16'hFF0F, 16'h0000, 1'b1);
        step(1);
        checkOutput("bypass_all_e5", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] bypass latency");
        din = 16'h0000;
        step(3);
        checkOutput("bypass_fall_e3", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("bypass_fall_e4", 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        step(1);
        checkOutput("bypass_fall_e5", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        din = 16'h0001;
        step(3);
        checkOutput("bypass_b0_e3", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("bypass_b0_e4", 16'h0001, 16'h0001, 16'h0000, 1'b1);
        step(1);
        checkOutput("bypass_b0_e5", 16'h0001, 16'h0000, 16'h0000, 1'b0);
        din = 16'h0000;
        step(4);
        checkOutput("bypass_b0_fall", 16'h0000, 16'h0000, 16'h0001, 1'b1);
        step(1);
        checkOutput("bypass_b0_quiet", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] glitch rejection");
        filt_en  = 1'b1;
        filt_len = 4'd4;
        din      = 16'h0020;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checkOutput("glitch_high", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        din = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            step(1);
            checkOutput("glitch_low", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        din = 16'h0020;
        for (int k = 0; k < 6; k++) begin
            step(1);
            checkOutput("filt4_wait", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        din = 16'h0000;
        step(1);
        checkOutput("filt4_rise", 16'h0020, 16'h0020, 16'h0000, 1'b1);
        step(1);
        checkOutput("filt4_hold", 16'h0020, 16'h0000, 16'h0000, 1'b0);
        step(4);
        checkOutput("filt4_fall_wait", 16'h0020, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("filt4_fall", 16'h0000, 16'h0000, 16'h0020, 1'b1);
        step(1);
        checkOutput("filt4_quiet", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] count restart");
        filt_len = 4'd5;
        din      = 16'h0004;
        step(3);
        din = 16'h0000;
        step(1);
        din = 16'h0004;
        for (int k = 0; k < 7; k++) begin
            step(1);
            checkOutput("restart_wait", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        step(1);
        checkOutput("restart_rise", 16'h0004, 16'h0004, 16'h0000, 1'b1);
        step(2);
        din = 16'h0000;
        step(8);
        checkOutput("restart_fall", 16'h0000, 16'h0000, 16'h0004, 1'b1);
        step(1);
        checkOutput("restart_quiet", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] runtime shrink");
        filt_len = 4'd15;
        din      = 16'h0002;
        step(9);
        checkOutput("shrink_cnt6", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        filt_len = 4'd3;
        step(1);
        checkOutput("shrink_apply", 16'h0002, 16'h0002, 16'h0000, 1'b1);
        filt_len = 4'd0;
        din      = 16'h0000;
        step(3);
        checkOutput("len0_e3", 16'h0002, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("len0_e4", 16'h0000, 16'h0000, 16'h0002, 1'b1);
        step(1);
        checkOutput("len0_quiet", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] multi-bit and reset mid-count");
        filt_len = 4'd2;
        din      = 16'hA5A5;
        step(4);
        checkOutput("multi_wait", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("multi_rise", 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1);
        step(1);
        checkOutput("multi_once", 16'hA5A5, 16'h0000, 16'h0000, 1'b0);
        din = 16'h0000;
        step(4);
        checkOutput("midcnt_cnt1", 16'hA5A5, 16'h0000, 16'h0000, 1'b0);
        rstn = 1'b0;
        step(1);
        checkOutput("midcnt_reset", 16'h00F0, 16'h0000, 16'h0000, 1'b0);
        rstn = 1'b1;
        step(4);
        checkOutput("midcnt_full_len", 16'h00F0, 16'h0000, 16'h0000, 1'b0);
        step(1);
        checkOutput("midcnt_fall", 16'h0000, 16'h0000, 16'h00F0, 1'b1);
        step(1);
        checkOutput("midcnt_quiet", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
